// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: oversampling UART RX bit sampler.
// Synchronises RX_IN, counts clocks within each bit, takes an odd number of
// samples centred on mid-bit and majority-votes them. Samples that disagree
// raise noise_flag. Prescale values too small for the full window fall back
// to a single mid-bit sample.
module uart_rx_sampler #(
    parameter int PRESCALE_W  = 6,
    parameter int NUM_SAMPLES = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic [PRESCALE_W-1:0] Prescale,
    input  logic                  data_samp_en,
    output logic [PRESCALE_W-1:0] edge_cnt,
    output logic                  sampled_bit,
    output logic                  sample_valid,
    output logic                  noise_flag,
    output logic                  bit_done,
    output logic                  config_err
);

    localparam int K  = NUM_SAMPLES >> 1;
    localparam int CW = $clog2(NUM_SAMPLES + 1);
    // Two guard bits so that half+K+2 cannot wrap for any Prescale
    localparam int XW = PRESCALE_W + 2;

    typedef enum logic [1:0] {IDLE, RUN, CFG_ERR} state_t;

    state_t                  state_q, state_d;
    logic [SYNC_STAGES-1:0]  sync_q, sync_d;
    logic [PRESCALE_W-1:0]   presc_q, presc_d;
    logic [PRESCALE_W-1:0]   cnt_q, cnt_d;
    logic [NUM_SAMPLES-1:0]  smp_q, smp_d;
    logic                    sb_q, sb_d;
    logic                    sv_q, sv_d;
    logic                    nf_q, nf_d;

    logic                    rx_s;
    logic [XW-1:0]           p_x, half_x, lo_x, hi_x, cnt_x;
    logic                    legal, full_ok, last_cyc, in_win, at_last;
    logic [NUM_SAMPLES-1:0]  smp_shift;
    logic [CW-1:0]           ones;

    assign rx_s = sync_q[SYNC_STAGES-1];

    // Sampling window and legality, derived from the frozen Prescale copy
    always_comb begin
        p_x      = XW'(presc_q);
        half_x   = p_x >> 1;
        legal    = !presc_q[0] && (p_x >= XW'(4));
        full_ok  = (half_x > XW'(K)) && (half_x + XW'(K) + XW'(2) <= p_x);
        lo_x     = full_ok ? half_x - XW'(K) : half_x;
        hi_x     = full_ok ? half_x + XW'(K) : half_x;
        cnt_x    = XW'(cnt_q);
        last_cyc = (cnt_x == p_x - XW'(1));
        in_win   = (state_q == RUN) && data_samp_en && (cnt_x >= lo_x) && (cnt_x <= hi_x);
        at_last  = in_win && (cnt_x == hi_x);
    end

    // Next state: enable rising picks RUN or CFG_ERR, enable falling returns to IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (data_samp_en) state_d = legal ? RUN : CFG_ERR;
            RUN:     if (!data_samp_en) state_d = IDLE;
            CFG_ERR: if (!data_samp_en) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath: synchroniser, shadow Prescale, bit counter, sample shift and vote
    always_comb begin
        sync_d    = {sync_q[SYNC_STAGES-2:0], RX_IN};
        presc_d   = data_samp_en ? presc_q : Prescale;

        // The first enabled cycle (still IDLE) shows edge_cnt 0, so it advances to 1
        cnt_d = '0;
        if (data_samp_en && ((state_q == RUN) || ((state_q == IDLE) && legal)))
            cnt_d = last_cyc ? '0 : cnt_q + PRESCALE_W'(1);

        smp_shift = NUM_SAMPLES'({smp_q, rx_s});
        ones      = '0;
        for (int i = 0; i < NUM_SAMPLES; i++)
            ones = ones + CW'(smp_shift[i]);

        smp_d = smp_q;
        if (!data_samp_en || (state_q != RUN) || last_cyc)
            smp_d = '0;
        else if (in_win)
            smp_d = smp_shift;

        sv_d = at_last;
        sb_d = sb_q;
        nf_d = nf_q;
        if (at_last) begin
            if (full_ok) begin
                sb_d = (ones > CW'(K));
                nf_d = (ones != '0) && (ones != CW'(NUM_SAMPLES));
            end else begin
                sb_d = rx_s;
                nf_d = 1'b0;
            end
        end
    end

    // State and datapath registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            sync_q  <= '1;
            presc_q <= '0;
            cnt_q   <= '0;
            smp_q   <= '0;
            sb_q    <= 1'b1;
            sv_q    <= 1'b0;
            nf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= sync_d;
            presc_q <= presc_d;
            cnt_q   <= cnt_d;
            smp_q   <= smp_d;
            sb_q    <= sb_d;
            sv_q    <= sv_d;
            nf_q    <= nf_d;
        end
    end

    // Outputs: bit_done and config_err decode straight from counter and state
    always_comb begin
        edge_cnt     = cnt_q;
        sampled_bit  = sb_q;
        sample_valid = sv_q;
        noise_flag   = nf_q;
        bit_done     = (state_q == RUN) && data_samp_en && last_cyc;
        config_err   = (state_q == CFG_ERR);
    end

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Directed bench for uart_rx_sampler: a vector table for the single-cycle
// behaviour plus hand sequences for the 5-sample vote and async reset.
module tb_uart_rx_sampler;

    logic       CLK = 1'b0;
    logic       RST, RX_IN, data_samp_en;
    logic [5:0] Prescale;
    logic [5:0] edge_cnt, edge_cnt5;
    logic       sampled_bit, sample_valid, noise_flag, bit_done, config_err;
    logic       sampled_bit5, sample_valid5, noise_flag5, bit_done5, config_err5;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    uart_rx_sampler #(.PRESCALE_W(6), .NUM_SAMPLES(3), .SYNC_STAGES(2)) dut (
        .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .Prescale(Prescale),
        .data_samp_en(data_samp_en), .edge_cnt(edge_cnt),
        .sampled_bit(sampled_bit), .sample_valid(sample_valid),
        .noise_flag(noise_flag), .bit_done(bit_done), .config_err(config_err)
    );

    uart_rx_sampler #(.PRESCALE_W(6), .NUM_SAMPLES(5), .SYNC_STAGES(2)) dut5 (
        .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .Prescale(Prescale),
        .data_samp_en(data_samp_en), .edge_cnt(edge_cnt5),
        .sampled_bit(sampled_bit5), .sample_valid(sample_valid5),
        .noise_flag(noise_flag5), .bit_done(bit_done5), .config_err(config_err5)
    );

    typedef struct {
        logic       rx;
        logic       en;
        logic [5:0] p;
        logic [5:0] ec;
        logic       sv, sb, nf, bd, ce;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input int rx, input int en, input int p, input int ec,
                       input int sv, input int sb, input int nf, input int bd, input int ce);
        vec_t v;
        v.rx = rx[0]; v.en = en[0]; v.p = 6'(p); v.ec = 6'(ec);
        v.sv = sv[0]; v.sb = sb[0]; v.nf = nf[0]; v.bd = bd[0]; v.ce = ce[0];
        vq.push_back(v);
    endtask

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " ec"}, 32'(edge_cnt), 32'(0));
        chk({tag, " sv"}, 32'(sample_valid), 32'(0));
        chk({tag, " sb"}, 32'(sampled_bit), 32'(1));
        chk({tag, " nf"}, 32'(noise_flag), 32'(0));
        chk({tag, " bd"}, 32'(bit_done), 32'(0));
        chk({tag, " ce"}, 32'(config_err), 32'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // A: P=8, line low; Prescale=16 shown mid-bit must be ignored
        for (int n = 0; n < 3; n++) add(0, 0, 8, 0, 0, 1, 0, 0, 0);
        for (int n = 0; n < 16; n++)
            add(0, 1, (n < 2) ? 8 : 16, n % 8, (n % 8 == 6) ? 1 : 0, (n < 6) ? 1 : 0, 0,
                (n % 8 == 7) ? 1 : 0, 0);
        // B: P=4 degraded, single sample at 2, valid and done together at 3
        for (int n = 0; n < 3; n++) add(1, 0, 4, 0, 0, 0, 0, 0, 0);
        for (int n = 0; n < 8; n++)
            add(1, 1, 4, n % 4, (n % 4 == 3) ? 1 : 0, (n >= 3) ? 1 : 0, 0,
                (n % 4 == 3) ? 1 : 0, 0);
        // C: P=5 then P=2 are illegal
        for (int n = 0; n < 2; n++) add(1, 0, 5, 0, 0, 1, 0, 0, 0);
        for (int n = 0; n < 4; n++) add(1, 1, 5, 0, 0, 1, 0, 0, (n >= 1) ? 1 : 0);
        add(1, 0, 2, 0, 0, 1, 0, 0, 1);
        add(1, 0, 2, 0, 0, 1, 0, 0, 0);
        for (int n = 0; n < 3; n++) add(1, 1, 2, 0, 0, 1, 0, 0, (n >= 1) ? 1 : 0);
        add(0, 0, 8, 0, 0, 1, 0, 0, 1);
        // D: abort at edge_cnt 4 with P=8, then P=16 applies after the drop
        for (int n = 0; n < 2; n++) add(0, 0, 8, 0, 0, 1, 0, 0, 0);
        for (int n = 0; n < 4; n++) add(0, 1, (n < 2) ? 8 : 16, n, 0, 1, 0, 0, 0);
        add(0, 0, 16, 4, 0, 1, 0, 0, 0);
        add(0, 0, 16, 0, 0, 1, 0, 0, 0);
        for (int n = 0; n < 16; n++)
            add(0, 1, 16, n, (n == 10) ? 1 : 0, (n < 10) ? 1 : 0, 0, (n == 15) ? 1 : 0, 0);

        // Reset state
        RST = 1'b1; RX_IN = 1'b1; data_samp_en = 1'b0; Prescale = 6'd8;
        #12;
        chk_reset_vals("reset");
        next_cycle();
        RST = 1'b0;

        foreach (vq[i]) begin
            RX_IN = vq[i].rx; data_samp_en = vq[i].en; Prescale = vq[i].p;
            @(negedge CLK);
            chk($sformatf("v%0d ec", i), 32'(edge_cnt), 32'(vq[i].ec));
            chk($sformatf("v%0d sv", i), 32'(sample_valid), 32'(vq[i].sv));
            chk($sformatf("v%0d sb", i), 32'(sampled_bit), 32'(vq[i].sb));
            chk($sformatf("v%0d nf", i), 32'(noise_flag), 32'(vq[i].nf));
            chk($sformatf("v%0d bd", i), 32'(bit_done), 32'(vq[i].bd));
            chk($sformatf("v%0d ce", i), 32'(config_err), 32'(vq[i].ce));
            next_cycle();
        end

        // E: P=16, rx_s = 1,0,1,1,0 at indices 6..10 (RX_IN leads by two cycles)
        RX_IN = 1'b1; data_samp_en = 1'b0; Prescale = 6'd16;
        next_cycle();
        next_cycle();
        for (int n = 0; n < 16; n++) begin
            case (n)
                5, 8:    RX_IN = 1'b0;
                default: RX_IN = 1'b1;
            endcase
            data_samp_en = 1'b1;
            @(negedge CLK);
            chk($sformatf("e%0d ec5", n), 32'(edge_cnt5), 32'(n));
            chk($sformatf("e%0d sv5", n), 32'(sample_valid5), (n == 11) ? 32'(1) : 32'(0));
            chk($sformatf("e%0d sv3", n), 32'(sample_valid), (n == 10) ? 32'(1) : 32'(0));
            if (n == 11) begin
                chk("e vote5 sb", 32'(sampled_bit5), 32'(1));
                chk("e vote5 nf", 32'(noise_flag5), 32'(1));
            end
            if (n == 10) begin
                chk("e vote3 sb", 32'(sampled_bit), 32'(1));
                chk("e vote3 nf", 32'(noise_flag), 32'(1));
            end
            next_cycle();
        end

        // F: async reset in the middle of a bit at edge_cnt 5
        RX_IN = 1'b0; data_samp_en = 1'b0; Prescale = 6'd8;
        next_cycle();
        next_cycle();
        data_samp_en = 1'b1;
        for (int n = 0; n < 13; n++) next_cycle();
        chk("f pre ec", 32'(edge_cnt), 32'(5));
        chk("f pre sb", 32'(sampled_bit), 32'(0));
        #2;
        RST = 1'b1;
        #1;
        chk_reset_vals("midrst");
        next_cycle();
        data_samp_en = 1'b0;
        RST = 1'b0;
        for (int n = 0; n < 3; n++) begin
            @(negedge CLK);
            chk($sformatf("post%0d ec", n), 32'(edge_cnt), 32'(0));
            chk($sformatf("post%0d sv", n), 32'(sample_valid), 32'(0));
            chk($sformatf("post%0d ce", n), 32'(config_err), 32'(0));
            next_cycle();
        end
        data_samp_en = 1'b1;
        for (int n = 0; n < 2; n++) begin
            @(negedge CLK);
            chk($sformatf("restart%0d ec", n), 32'(edge_cnt), 32'(n));
            next_cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_sampler.md
# uart_rx_sampler

Parametrised UART receive sampler, the successor to the fixed three-sample RX data sampler. It owns its own per-bit oversampling counter and a metastability synchroniser. It takes a configurable odd number of samples centred on mid-bit and majority-votes them, flagging noisy bits. It sits between the RX pin and the RX FSM, which consumes `sampled_bit`, `sample_valid`, `bit_done` and `edge_cnt`.

## Interface
- `PRESCALE_W`, default 6: width of `Prescale` and `edge_cnt`.
- `NUM_SAMPLES`, default 3: samples per bit; must be odd and in the range 1..7.
- `SYNC_STAGES`, default 2: RX_IN synchroniser depth; must be ≥2.
- `CLK`  in  1: oversampling clock; single clock domain.
- `RST`  in  1: reset, asynchronous, active-high.
- `RX_IN`  in  1: asynchronous serial line.
- `Prescale`  in  PRESCALE_W: oversampling ratio, clocks per bit.
- `data_samp_en`  in  1: high while the FSM is inside a frame. Falling aborts the current bit.
- `edge_cnt`  out  PRESCALE_W: position within the current bit, 0..Prescale-1.
- `sampled_bit`  out  1: voted bit value; holds between updates.
- `sample_valid`  out  1: one-cycle pulse when `sampled_bit` is updated.
- `noise_flag`  out  1: samples of the last voted bit were not unanimous; updated with `sample_valid`.
- `bit_done`  out  1: one-cycle pulse in the last cycle of a bit (`edge_cnt == Prescale-1`).
- `config_err`  out  1: latched Prescale is illegal.

## Operation
- Synchroniser: `SYNC_STAGES` flops on RX_IN, reset to 1. All sampling uses the synchronised value `rx_s`.
- Prescale shadow register: loads every cycle `data_samp_en` is low and is frozen while it is high. Prescale must be stable ≥1 cycle before `data_samp_en` rises.
- Legality:
  - Prescale is illegal if it is odd or < 4.
  - Let `half = Prescale>>1` and `k = NUM_SAMPLES>>1`.
  - Full window: indices half-k .. half+k. It is used if half-k ≥ 1 and half+k ≤ Prescale-2.
  - Otherwise degraded mode: a single sample at index `half`, with `noise_flag` forced to 0.
- FSM states:
  - IDLE: `data_samp_en` low. `edge_cnt` = 0, sample register cleared.
  - RUN: counting.
  - CFG_ERR: `config_err` = 1, no counting, no pulses.
- Transitions:
  - IDLE→RUN when `data_samp_en` rises and Prescale is legal.
  - IDLE→CFG_ERR when `data_samp_en` rises and Prescale is illegal.
  - RUN→IDLE and CFG_ERR→IDLE when `data_samp_en` falls.
- Counter: in the n-th cycle (n = 0 first) with `data_samp_en` high, `edge_cnt = n mod Prescale`. It wraps Prescale-1 → 0 without a gap.
- Sampling: in each cycle where `edge_cnt` equals a window index, `rx_s` is shifted into the sample register.
- Vote:
  - `sampled_bit` = 1 iff the count of ones > NUM_SAMPLES>>1. The count register is clog2(NUM_SAMPLES+1) bits.
  - `noise_flag` = 1 iff the count is neither 0 nor NUM_SAMPLES.
- The sample register clears at each bit wrap.

## Timing
- Reset values:
  - `sampled_bit` = 1 and synchroniser = all 1s.
  - `edge_cnt`, `sample_valid`, `noise_flag`, `bit_done` and `config_err` = 0.
  - FSM = IDLE.
- Reset mid-bit clears state immediately; no pulse is emitted.
- RX_IN reaches `rx_s` after SYNC_STAGES cycles. The upstream start-edge detector accounts for this.
- `sample_valid` is registered. It pulses in the cycle after the last window index, i.e. at `edge_cnt` = last index + 1 (≤ Prescale-1). `sampled_bit` and `noise_flag` change in that same cycle.
- `bit_done` is combinational from `edge_cnt` and the state. It may coincide with `sample_valid` when last index = Prescale-2; both are asserted.
- `data_samp_en` falling before the last sample:
  - No `sample_valid` for that bit.
  - `sampled_bit` and `noise_flag` hold.
  - `edge_cnt` is 0 the next cycle.
- Prescale changes while `data_samp_en` is high are ignored until the next IDLE.
- `edge_cnt` cannot overflow PRESCALE_W, since it wraps at Prescale-1.

## Test plan
- Prescale=8, NUM_SAMPLES=3, line held 0 → samples at `edge_cnt` 3,4,5; `sample_valid` at `edge_cnt`=6 with `sampled_bit`=0, `noise_flag`=0; `bit_done` at 7, repeating every 8 cycles.
- Prescale=16, NUM_SAMPLES=5, `rx_s` pattern 1,0,1,1,0 at indices 6..10 → `sampled_bit`=1 and `noise_flag`=1 at `edge_cnt`=11.
- Prescale=4, NUM_SAMPLES=3 → degraded mode: single sample at index 2, `sample_valid` at 3 together with `bit_done`, `noise_flag`=0.
- Prescale=5, or Prescale=2, then `data_samp_en` raised → `config_err`=1, no pulses, `edge_cnt`=0. Lowering `data_samp_en` clears `config_err`.
- `data_samp_en` dropped at `edge_cnt`=4 with Prescale=8 → no `sample_valid`, `sampled_bit` keeps its prior value, `edge_cnt`=0 next cycle. Prescale=16 presented while the enable was high takes effect only after the enable drops.
- `RST` asserted mid-bit at `edge_cnt`=5 → all outputs return to reset values asynchronously. After release with `data_samp_en` low the block stays in IDLE.
